// File: rtl/mac_pkg.sv
// Shared types and widths for the 4-bit multiply-accumulate sequencer.
package mac_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage : mac_pkg

// File: rtl/multiplier_4b.sv
// Exact combinational 4x4 unsigned multiplier. Approximate variants with the
// same ports can replace this module without touching the sequencer.
module multiplier_4b
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic [PROD_W-1:0] mul_p
);

    // Full-precision product; operands are widened so no bits are lost.
    always_comb begin
        mul_p = PROD_W'(op_a) * PROD_W'(op_b);
    end

endmodule : multiplier_4b

// File: rtl/mac_sequencer.sv
// Job sequencer around multiplier_4b: takes a job length, streams that many
// operand pairs through the multiplier and returns the dot-product sum.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; out_acc still shows the previous result
// RUN   | accepting operand pairs, one per cycle, gaps allowed
// FLUSH | last product is in flight; add it, accept nothing
// DONE  | result presented on out_valid until the consumer takes it
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    mac_state_t         state;
    mac_state_t         state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic               pv;
    logic [PROD_W-1:0]  mul_p;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic [ACC_W:0]     sum;
    logic               load_job;
    logic               beat;
    logic               last_beat;

    multiplier_4b u_mul (
        .op_a  (op_a),
        .op_b  (op_b),
        .mul_p (mul_p)
    );

    // Handshake qualifiers derived from the current state.
    always_comb begin
        load_job  = (state == IDLE) && start;
        beat      = (state == RUN) && in_valid;
        last_beat = beat && (remaining == LEN_W'(1));
    end

    // One extra bit catches the carry out of the accumulator width.
    always_comb begin
        sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, mul_p};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Beat counter, operand capture and product-pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            op_a      <= '0;
            op_b      <= '0;
            pv        <= 1'b0;
        end else if (load_job) begin
            remaining <= len;
            pv        <= 1'b0;
        end else if (state == RUN) begin
            if (beat) begin
                op_a      <= in_a;
                op_b      <= in_b;
                pv        <= 1'b1;
                remaining <= remaining - LEN_W'(1);
            end else begin
                pv <= 1'b0;
            end
        end else if (state == FLUSH) begin
            pv <= 1'b0;
        end
    end

    // Accumulator with sticky carry-out; cleared only when a new job starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (load_job) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (pv) begin
            acc <= sum[ACC_W-1:0];
            if (sum[ACC_W]) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_acc = acc;
    assign out_ovf = ovf;

endmodule : mac_sequencer

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a 16-bit and an 8-bit accumulator
// instance share one stimulus stream so wrap/overflow is visible on the
// narrow copy while the wide copy holds the exact sum.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_a = '0;
    logic [3:0]  in_b = '0;
    logic        out_ready = 1'b0;

    logic        busy16, in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_acc16;
    logic        busy8, in_ready8, out_valid8, out_ovf8;
    logic [7:0]  out_acc8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy16),
        .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16), .out_ovf(out_ovf16)
    );

    mac_sequencer #(.ACC_W(8), .LEN_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy8),
        .in_valid(in_valid), .in_ready(in_ready8), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid8), .out_ready(out_ready),
        .out_acc(out_acc8), .out_ovf(out_ovf8)
    );

    typedef struct {
        string       name;
        int          n;
        logic [15:0] a;      // pair k operand a in nibble k
        logic [15:0] b;
        int          acc16;
        int          ovf16;
        int          acc8;
        int          ovf8;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a job and stream its pairs back-to-back, checking the
    // RUN -> FLUSH -> DONE timing along the way.
    task automatic run_job(input string name, input int n,
                           input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        chk({name, "_busy"}, int'(busy16), 1);
        if (n == 0) begin
            chk({name, "_zero_ovalid"}, int'(out_valid16), 1);
            chk({name, "_zero_iready"}, int'(in_ready16), 0);
        end else begin
            for (int k = 0; k < n; k++) begin
                chk({name, "_iready"}, int'(in_ready16), 1);
                in_valid = 1'b1;
                in_a     = a[4*k +: 4];
                in_b     = b[4*k +: 4];
                tick();
            end
            in_valid = 1'b0;
            chk({name, "_flush_iready"}, int'(in_ready16), 0);
            chk({name, "_flush_ovalid"}, int'(out_valid16), 0);
            tick();
            chk({name, "_ovalid"}, int'(out_valid16), 1);
            chk({name, "_ovalid8"}, int'(out_valid8), 1);
        end
    endtask

    task automatic finish_job(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_idle_busy"}, int'(busy16), 0);
        chk({name, "_idle_ovalid"}, int'(out_valid16), 0);
    endtask

    initial begin
        vecs[0] = '{"basic",  3, 16'h02F3, 16'h07F5, 254, 0, 254, 0};
        vecs[1] = '{"ovf2",   2, 16'h00FF, 16'h00FF, 450, 0, 194, 1};
        vecs[2] = '{"one",    1, 16'h0001, 16'h0001,   1, 0,   1, 0};
        vecs[3] = '{"zero",   0, 16'h0000, 16'h0000,   0, 0,   0, 0};
        vecs[4] = '{"ovf4",   4, 16'hFFFF, 16'hFFFF, 900, 0, 132, 1};
        vecs[5] = '{"mixed",  3, 16'h0A07, 16'h0C49, 183, 0, 183, 0};

        // Reset state.
        repeat (2) tick();
        chk("rst_busy", int'(busy16), 0);
        chk("rst_iready", int'(in_ready16), 0);
        chk("rst_ovalid", int'(out_valid16), 0);
        chk("rst_acc", int'(out_acc16), 0);
        chk("rst_ovf", int'(out_ovf16), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven jobs.
        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].name, vecs[i].n, vecs[i].a, vecs[i].b);
            chk({vecs[i].name, "_acc16"}, int'(out_acc16), vecs[i].acc16);
            chk({vecs[i].name, "_ovf16"}, int'(out_ovf16), vecs[i].ovf16);
            chk({vecs[i].name, "_acc8"},  int'(out_acc8),  vecs[i].acc8);
            chk({vecs[i].name, "_ovf8"},  int'(out_ovf8),  vecs[i].ovf8);
            finish_job(vecs[i].name);
        end

        // Backpressure: gapped input, consumer stalls five cycles.
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        in_a  = 4'd1;
        in_b  = 4'd1;
        for (int k = 0; k < 8; k++) begin
            in_valid = (k % 2 == 0);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_flush_iready", int'(in_ready16), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_ovalid", int'(out_valid16), 1);
            chk("bp_hold_acc", int'(out_acc16), 4);
            tick();
        end
        finish_job("bp");
        chk("bp_idle_acc_held", int'(out_acc16), 4);

        // Reset in the middle of a job.
        start = 1'b1;
        len   = 8'd5;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 4'd3;
        in_b = 4'd3;
        repeat (2) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy16), 0);
        chk("mid_rst_iready", int'(in_ready16), 0);
        chk("mid_rst_ovalid", int'(out_valid16), 0);
        chk("mid_rst_acc", int'(out_acc16), 0);
        chk("mid_rst_ovf", int'(out_ovf16), 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job("after_rst", 1, 16'h0007, 16'h0009);
        chk("after_rst_acc", int'(out_acc16), 63);
        finish_job("after_rst");

        // Requests that must be ignored outside their window.
        start = 1'b1;
        len   = 8'd2;
        tick();
        len      = 8'd9;
        in_valid = 1'b1;
        in_a = 4'd2;
        in_b = 4'd3;
        tick();
        in_a = 4'd4;
        in_b = 4'd5;
        tick();
        chk("ign_run_start_flush", int'(in_ready16), 0);
        tick();
        chk("ign_ovalid", int'(out_valid16), 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ign_done_ovalid", int'(out_valid16), 1);
            chk("ign_done_acc", int'(out_acc16), 26);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        finish_job("ign");
        tick();
        chk("ign_no_spawn", int'(busy16), 0);
        chk("ign_acc_held", int'(out_acc16), 26);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_mac_sequencer
